// File: rtl/fsm_pkg.sv
// Shared definitions for the jump/branch control-flow FSM: state encoding,
// branch funct3 codes, opdecoder bit indices and the registered control word.
package fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC_J  = 3'd2,
    S_EXEC_B  = 3'd3,
    S_RESOLVE = 3'd4,
    S_WB_J    = 3'd5,
    S_WB_B    = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CODE_BRANCH = 24;
  localparam int CODE_JALR   = 25;

  // Every registered DataFlow control, kept together so reset and the
  // next-state decode treat them as one word.
  typedef struct packed {
    logic sel_pc_next;
    logic sel_pc_alu;
    logic load_pc;
    logic sub_sra;
    logic load_regfile;
    logic load_rs1;
    logic load_rs2;
    logic load_alu;
    logic load_imm;
    logic sel_alu_a;
    logic sel_alu_b;
    logic load_pc_alu;
    logic load_flags;
    logic clr_lsb;
    logic link_step2;
    logic done;
    logic trap_misaligned;
    logic trap_illegal;
  } ctrl_t;

endpackage

// File: rtl/fsm_ctrl_flow_branch_cond.sv
// Combinational branch condition: funct3 plus ALU flags give the taken
// decision and whether the funct3 is an undefined branch encoding.
module branch_cond
  import fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_branch,
  input  logic       lu,
  input  logic       ls,
  input  logic       eq,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = ls;
      F3_BGE:  taken = ~ls;
      F3_BLTU: taken = lu;
      F3_BGEU: taken = ~lu;
      default: taken = 1'b0;
    endcase
  end

  assign illegal = is_branch & ((funct3 == 3'b010) | (funct3 == 3'b011));

endmodule

// File: rtl/fsm_ctrl_flow.sv
// Control-flow FSM sequencing JAL, JALR and B-type branches through the
// binary-ALU DataFlow, with start/busy/done handshake and trap resolution.
module fsm_ctrl_flow
  import fsm_pkg::*;
#(
  parameter int                      IALIGN      = 32,
  parameter int                      SEL_RD_W    = 2,
  parameter logic [SEL_RD_W-1:0]     SEL_RD_LINK = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ins,
  input  logic [31:0]         code,
  input  logic                ins_c,
  input  logic                start,
  input  logic                lu,
  input  logic                ls,
  input  logic                eq,
  input  logic [1:0]          tgt_lsb,
  output logic [2:0]          func3,
  output logic [SEL_RD_W-1:0] sel_rd,
  output logic                load_data_memory,
  output logic                write_mem,
  output logic                sel_pc_next,
  output logic                sel_pc_alu,
  output logic                load_pc,
  output logic                sub_sra,
  output logic                load_regfile,
  output logic                load_rs1,
  output logic                load_rs2,
  output logic                load_alu,
  output logic                load_imm,
  output logic                sel_alu_a,
  output logic                sel_alu_b,
  output logic                load_pc_alu,
  output logic                load_flags,
  output logic                clr_lsb,
  output logic                link_step2,
  output logic                busy,
  output logic                done,
  output logic                trap_misaligned,
  output logic                trap_illegal
);

  localparam bit ALIGN16 = (IALIGN == 16);

  state_t state, state_next;
  ctrl_t  ctrl_q, ctrl_next;
  logic   taken_q, taken_next;

  logic   is_branch, is_jalr;
  logic   taken_raw, illegal_f3;
  logic   illegal, misaligned, trap_mis;
  logic   unused_bits;

  assign is_branch = code[CODE_BRANCH];
  assign is_jalr   = code[CODE_JALR];

  branch_cond u_branch_cond (
    .funct3    (ins[14:12]),
    .is_branch (is_branch),
    .lu        (lu),
    .ls        (ls),
    .eq        (eq),
    .taken     (taken_raw),
    .illegal   (illegal_f3)
  );

  // Compressed instructions are only legal when the core supports 16-bit
  // alignment; with 16-bit alignment no target can be misaligned.
  assign illegal    = illegal_f3 | (ins_c & ~ALIGN16);
  assign misaligned = ~ALIGN16 & (tgt_lsb[1] | (tgt_lsb[0] & ~is_jalr));
  assign trap_mis   = (~is_branch | taken_raw) & misaligned;

  always_comb begin
    // NOTE: combinational logic uses blocking '=', state registers use '<='.
    state_next = state;
    taken_next = taken_q;
    unique case (state)
      S_IDLE:    if (start) state_next = S_DECODE;
      S_DECODE:  state_next = is_branch ? S_EXEC_B : S_EXEC_J;
      S_EXEC_J,
      S_EXEC_B:  state_next = S_RESOLVE;
      S_RESOLVE: begin
        taken_next = taken_raw;
        if (illegal || trap_mis) state_next = S_TRAP;
        else                     state_next = is_branch ? S_WB_B : S_WB_J;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered value is
  // aligned with the state it belongs to.
  always_comb begin
    ctrl_next = '0;
    unique case (state_next)
      S_DECODE: begin
        ctrl_next.load_rs1 = 1'b1;
        ctrl_next.load_rs2 = 1'b1;
        ctrl_next.load_imm = 1'b1;
      end
      S_EXEC_J: begin
        ctrl_next.sel_alu_a   = ~is_jalr;
        ctrl_next.sel_alu_b   = 1'b1;
        ctrl_next.load_alu    = 1'b1;
        ctrl_next.load_pc_alu = 1'b1;
        ctrl_next.clr_lsb     = is_jalr;
      end
      S_EXEC_B: begin
        ctrl_next.sub_sra    = 1'b1;
        ctrl_next.load_flags = 1'b1;
      end
      S_WB_J: begin
        ctrl_next.load_regfile = 1'b1;
        ctrl_next.sel_pc_next  = 1'b1;
        ctrl_next.load_pc      = 1'b1;
        ctrl_next.done         = 1'b1;
      end
      S_WB_B: begin
        ctrl_next.load_pc    = 1'b1;
        ctrl_next.sel_pc_alu = taken_next;
        ctrl_next.done       = 1'b1;
      end
      S_TRAP: begin
        ctrl_next.done            = 1'b1;
        ctrl_next.trap_illegal    = illegal;
        ctrl_next.trap_misaligned = ~illegal;
      end
      default: ;
    endcase
    ctrl_next.link_step2 = ins_c & ALIGN16 & (state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ctrl_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_next;
      ctrl_q  <= ctrl_next;
      taken_q <= taken_next;
    end
  end

  assign busy             = (state != S_IDLE);
  assign func3            = 3'b000;
  assign sel_rd           = SEL_RD_LINK;
  assign load_data_memory = 1'b0;
  assign write_mem        = 1'b0;

  assign sel_pc_next     = ctrl_q.sel_pc_next;
  assign sel_pc_alu      = ctrl_q.sel_pc_alu;
  assign load_pc         = ctrl_q.load_pc;
  assign sub_sra         = ctrl_q.sub_sra;
  assign load_regfile    = ctrl_q.load_regfile;
  assign load_rs1        = ctrl_q.load_rs1;
  assign load_rs2        = ctrl_q.load_rs2;
  assign load_alu        = ctrl_q.load_alu;
  assign load_imm        = ctrl_q.load_imm;
  assign sel_alu_a       = ctrl_q.sel_alu_a;
  assign sel_alu_b       = ctrl_q.sel_alu_b;
  assign load_pc_alu     = ctrl_q.load_pc_alu;
  assign load_flags      = ctrl_q.load_flags;
  assign clr_lsb         = ctrl_q.clr_lsb;
  assign link_step2      = ctrl_q.link_step2;
  assign done            = ctrl_q.done;
  assign trap_misaligned = ctrl_q.trap_misaligned;
  assign trap_illegal    = ctrl_q.trap_illegal;

  // Only funct3 and the two opdecoder bits steer this FSM.
  assign unused_bits = ^{ins[31:15], ins[11:0], code[31:26], code[23:0]};

endmodule

// File: tb/tb_fsm_ctrl_flow.sv
// Self-checking bench: two instances (IALIGN=32 and IALIGN=16) driven by the
// same directed and random operations, compared against a rule-level model.
module tb_fsm_ctrl_flow;

  localparam int B_SEL_PC_NEXT = 0;
  localparam int B_SEL_PC_ALU  = 1;
  localparam int B_LOAD_PC     = 2;
  localparam int B_SUB_SRA     = 3;
  localparam int B_LOAD_RF     = 4;
  localparam int B_LOAD_RS1    = 5;
  localparam int B_LOAD_RS2    = 6;
  localparam int B_LOAD_ALU    = 7;
  localparam int B_LOAD_IMM    = 8;
  localparam int B_SEL_ALU_A   = 9;
  localparam int B_SEL_ALU_B   = 10;
  localparam int B_LOAD_PC_ALU = 11;
  localparam int B_LOAD_FLAGS  = 12;
  localparam int B_CLR_LSB     = 13;
  localparam int B_LINK2       = 14;
  localparam int B_BUSY        = 15;
  localparam int B_DONE        = 16;
  localparam int B_TRAP_MIS    = 17;
  localparam int B_TRAP_ILL    = 18;

  localparam logic [31:0] C_JAL    = 32'h0080_0000;
  localparam logic [31:0] C_JALR   = 32'h0200_0000;
  localparam logic [31:0] C_BRANCH = 32'h0100_0000;
  localparam logic [6:0]  K_EXP    = 7'b000_11_0_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ins_c;
  logic        lu, ls, eq;
  logic [31:0] ins, code;
  logic [1:0]  tgt_lsb;
  wire  [18:0] o32, o16;
  wire  [6:0]  k32, k16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fsm_ctrl_flow #(.IALIGN(32)) dut32 (
    .clk(clk), .rst(rst), .ins(ins), .code(code), .ins_c(ins_c), .start(start),
    .lu(lu), .ls(ls), .eq(eq), .tgt_lsb(tgt_lsb),
    .func3(k32[6:4]), .sel_rd(k32[3:2]), .load_data_memory(k32[1]), .write_mem(k32[0]),
    .sel_pc_next(o32[B_SEL_PC_NEXT]), .sel_pc_alu(o32[B_SEL_PC_ALU]), .load_pc(o32[B_LOAD_PC]),
    .sub_sra(o32[B_SUB_SRA]), .load_regfile(o32[B_LOAD_RF]), .load_rs1(o32[B_LOAD_RS1]),
    .load_rs2(o32[B_LOAD_RS2]), .load_alu(o32[B_LOAD_ALU]), .load_imm(o32[B_LOAD_IMM]),
    .sel_alu_a(o32[B_SEL_ALU_A]), .sel_alu_b(o32[B_SEL_ALU_B]), .load_pc_alu(o32[B_LOAD_PC_ALU]),
    .load_flags(o32[B_LOAD_FLAGS]), .clr_lsb(o32[B_CLR_LSB]), .link_step2(o32[B_LINK2]),
    .busy(o32[B_BUSY]), .done(o32[B_DONE]), .trap_misaligned(o32[B_TRAP_MIS]),
    .trap_illegal(o32[B_TRAP_ILL])
  );

  fsm_ctrl_flow #(.IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .ins(ins), .code(code), .ins_c(ins_c), .start(start),
    .lu(lu), .ls(ls), .eq(eq), .tgt_lsb(tgt_lsb),
    .func3(k16[6:4]), .sel_rd(k16[3:2]), .load_data_memory(k16[1]), .write_mem(k16[0]),
    .sel_pc_next(o16[B_SEL_PC_NEXT]), .sel_pc_alu(o16[B_SEL_PC_ALU]), .load_pc(o16[B_LOAD_PC]),
    .sub_sra(o16[B_SUB_SRA]), .load_regfile(o16[B_LOAD_RF]), .load_rs1(o16[B_LOAD_RS1]),
    .load_rs2(o16[B_LOAD_RS2]), .load_alu(o16[B_LOAD_ALU]), .load_imm(o16[B_LOAD_IMM]),
    .sel_alu_a(o16[B_SEL_ALU_A]), .sel_alu_b(o16[B_SEL_ALU_B]), .load_pc_alu(o16[B_LOAD_PC_ALU]),
    .load_flags(o16[B_LOAD_FLAGS]), .clr_lsb(o16[B_CLR_LSB]), .link_step2(o16[B_LINK2]),
    .busy(o16[B_BUSY]), .done(o16[B_DONE]), .trap_misaligned(o16[B_TRAP_MIS]),
    .trap_illegal(o16[B_TRAP_ILL])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    return r;
  endfunction

  // Expected control word for phase 0..4 (decode, exec, resolve, final, idle),
  // derived from the operation's architectural outcome.
  function automatic logic [18:0] expect_vec(input int ph, input bit a16,
      input logic [31:0] i, input logic [31:0] c, input bit ic,
      input bit flu, input bit fls, input bit feq, input logic [1:0] t);
    logic [18:0] v;
    bit is_b, jalr, tk, ill, mis;
    int f3;
    is_b = c[24];
    jalr = c[25];
    f3   = int'(i[14:12]);
    case (f3)
      0: tk = feq;   1: tk = !feq;
      4: tk = fls;   5: tk = !fls;
      6: tk = flu;   7: tk = !flu;
      default: tk = 1'b0;
    endcase
    ill = (is_b && (f3 == 2 || f3 == 3)) || (ic && !a16);
    mis = !a16 && (t[1] || (t[0] && !jalr));
    v = '0;
    if (ph < 4) begin
      v[B_BUSY]  = 1'b1;
      v[B_LINK2] = ic && a16;
    end
    case (ph)
      0: begin v[B_LOAD_RS1] = 1; v[B_LOAD_RS2] = 1; v[B_LOAD_IMM] = 1; end
      1: if (is_b) begin
           v[B_SUB_SRA] = 1; v[B_LOAD_FLAGS] = 1;
         end else begin
           v[B_SEL_ALU_A] = !jalr; v[B_SEL_ALU_B] = 1; v[B_LOAD_ALU] = 1;
           v[B_LOAD_PC_ALU] = 1; v[B_CLR_LSB] = jalr;
         end
      3: begin
        v[B_DONE] = 1'b1;
        if (ill)                      v[B_TRAP_ILL] = 1'b1;
        else if ((!is_b || tk) && mis) v[B_TRAP_MIS] = 1'b1;
        else if (is_b) begin v[B_LOAD_PC] = 1; v[B_SEL_PC_ALU] = tk; end
        else begin v[B_LOAD_RF] = 1; v[B_SEL_PC_NEXT] = 1; v[B_LOAD_PC] = 1; end
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic scramble_flags();
    lu = 1'($urandom); ls = 1'($urandom); eq = 1'($urandom);
    tgt_lsb = 2'($urandom);
  endtask

  // Issues one operation at a falling edge and checks every phase through the
  // idle cycle that follows done. Flags carry noise except during RESOLVE.
  task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] c,
      input bit ic, input bit flu, input bit fls, input bit feq, input logic [1:0] t,
      input bit hold);
    ins = i; code = c; ins_c = ic; start = 1'b1;
    scramble_flags();
    @(negedge clk);
    start = hold;
    for (int ph = 0; ph < 5; ph++) begin
      check($sformatf("%s_p%0d_a32", tag, ph), 32'(o32), 32'(expect_vec(ph, 1'b0, i, c, ic, flu, fls, feq, t)));
      check($sformatf("%s_p%0d_a16", tag, ph), 32'(o16), 32'(expect_vec(ph, 1'b1, i, c, ic, flu, fls, feq, t)));
      if (ph == 2) begin
        lu = flu; ls = fls; eq = feq; tgt_lsb = t;
      end else begin
        scramble_flags();
      end
      if (ph < 4) @(negedge clk);
    end
    check({tag, "_const32"}, 32'(k32), 32'(K_EXP));
    check({tag, "_const16"}, 32'(k16), 32'(K_EXP));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ins = '0; code = '0; ins_c = 1'b0;
    lu = 1'b0; ls = 1'b0; eq = 1'b0; tgt_lsb = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_o32", 32'(o32), 32'h0);
    check("reset_o16", 32'(o16), 32'h0);
    check("reset_k32", 32'(k32), 32'(K_EXP));
    rst = 1'b0;
    @(negedge clk);

    run_op("jal",        mk_ins(3'b000), C_JAL,    1'b0, 0, 0, 0, 2'b00, 1'b0);
    run_op("jalr_lsb01", mk_ins(3'b000), C_JALR,   1'b0, 0, 0, 0, 2'b01, 1'b0);
    run_op("blt_taken",  mk_ins(3'b100), C_BRANCH, 1'b0, 0, 1, 0, 2'b00, 1'b0);
    run_op("bgeu_nt",    mk_ins(3'b111), C_BRANCH, 1'b0, 1, 0, 0, 2'b00, 1'b0);
    run_op("f3_010",     mk_ins(3'b010), C_BRANCH, 1'b0, 1, 1, 1, 2'b00, 1'b0);
    run_op("f3_011",     mk_ins(3'b011), C_BRANCH, 1'b0, 0, 0, 0, 2'b00, 1'b0);
    run_op("bne_mis",    mk_ins(3'b001), C_BRANCH, 1'b0, 0, 0, 0, 2'b10, 1'b0);
    run_op("bne_nt_mis", mk_ins(3'b001), C_BRANCH, 1'b0, 0, 0, 1, 2'b10, 1'b0);
    run_op("jal_c",      mk_ins(3'b000), C_JAL,    1'b1, 0, 0, 0, 2'b10, 1'b0);
    run_op("jal_lsb01",  mk_ins(3'b000), C_JAL,    1'b0, 0, 0, 0, 2'b01, 1'b0);
    run_op("b2b_first",  mk_ins(3'b000), C_JAL,    1'b0, 0, 0, 0, 2'b00, 1'b1);
    run_op("b2b_second", mk_ins(3'b000), C_BRANCH, 1'b0, 0, 0, 1, 2'b00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] c;
      int kind;
      kind = int'($urandom_range(3, 0));
      c = (kind == 0) ? C_JAL : (kind == 1) ? C_JALR : C_BRANCH;
      run_op($sformatf("rnd%0d", n), mk_ins(3'($urandom)), c,
             ($urandom_range(3, 0) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom), 1'($urandom));
    end

    // Abort in EXEC_B: outputs clear asynchronously and nothing completes later.
    ins = mk_ins(3'b000); code = C_BRANCH; ins_c = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_pre_execb", 32'(o32), 32'(expect_vec(1, 1'b0, ins, code, 1'b0, 0, 0, 0, 2'b00)));
    #2 rst = 1'b1;
    #1;
    check("rst_async_o32", 32'(o32), 32'h0);
    check("rst_async_o16", 32'(o16), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d_o32", n), 32'(o32), 32'h0);
      check($sformatf("rst_after%0d_o16", n), 32'(o16), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl_flow.md
# fsm_ctrl_flow

Parametrised control-flow FSM for the Control Unit; the next generation of the jump/branch state machine. It sequences JAL, JALR and all B-type branches through the binary-ALU DataFlow. Over the previous generation it adds:
- a start/busy/done handshake;
- asynchronous reset;
- a RESOLVE state for misaligned-target and illegal-funct3 traps;
- optional 16-bit instruction alignment (compressed link step).

## Interface
Parameters:
- IALIGN, 32, instruction alignment in bits; legal values are 32 and 16.
- SEL_RD_W, 2, width of the rd write-back selector.
- SEL_RD_LINK, 2'b11, sel_rd value that selects the PC-ALU (link) path.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins  in  32  instruction (expanded 32-bit form); funct3 = ins[14:12].
- code  in  32  opdecoder one-hot; code[24] = branch, code[25] = JALR.
- ins_c  in  1  instruction was originally 16-bit.
- start  in  1  begin sequencing; sampled in IDLE only.
- lu, ls, eq  in  1 each  ALU comparison flags (unsigned-less, signed-less, equal).
- tgt_lsb  in  2  low two bits of the candidate target (ALU result for jumps, branch target for branches).
- func3  out  3  ALU function; constant 3'b000.
- sel_rd  out  SEL_RD_W  constant SEL_RD_LINK.
- load_data_memory, write_mem  out  1 each  constant 0.
- sel_pc_next, sel_pc_alu, load_pc, sub_sra, load_regfile, load_rs1, load_rs2, load_alu, load_imm, sel_alu_a, sel_alu_b, load_pc_alu, load_flags  out  1 each  DataFlow controls.
- clr_lsb  out  1  ALU result bit 0 forced to 0 (JALR).
- link_step2  out  1  link value is pc+2 instead of pc+4.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- trap_misaligned, trap_illegal  out  1 each  one-cycle trap pulses, coincident with done.

## Operation
- States: IDLE, DECODE, EXEC_J, EXEC_B, RESOLVE, WB_J, WB_B, TRAP (3-bit encoding).
- Outputs are registered and decoded from next-state, so each output is valid during the state it belongs to. Any output not listed for a state is 0.
- IDLE:
  - start=1 -> DECODE.
  - While busy, start is ignored.
- DECODE:
  - Outputs: load_rs1, load_rs2, load_imm.
  - Transition: code[24] ? EXEC_B : EXEC_J.
- EXEC_J:
  - sel_alu_a = ~code[25] (0 selects rs1 for JALR, 1 selects PC).
  - sel_alu_b = 1, load_alu = 1, load_pc_alu = 1.
  - clr_lsb = code[25].
  - Transition: -> RESOLVE.
- EXEC_B:
  - sub_sra = 1, load_flags = 1.
  - Transition: -> RESOLVE.
- RESOLVE (no DataFlow loads):
  - Branch taken latch from funct3: 000 eq, 001 ~eq, 100 ls, 101 ~ls, 110 lu, 111 ~lu.
  - misaligned = (IALIGN==32) & (tgt_lsb[1] | (tgt_lsb[0] & ~code[25])). This is never true when IALIGN=16.
  - illegal = (branch & funct3 in {010, 011}) | (ins_c & IALIGN==32).
  - Transition: illegal -> TRAP. Else (jump | taken) & misaligned -> TRAP. Else jump -> WB_J, branch -> WB_B.
  - A not-taken branch never traps on alignment.
- WB_J:
  - load_regfile = 1, sel_pc_next = 1, load_pc = 1, done = 1.
  - Transition: -> IDLE.
- WB_B:
  - load_pc = 1, sel_pc_alu = taken latch, done = 1.
  - Transition: -> IDLE.
- TRAP:
  - done = 1, plus trap_illegal or trap_misaligned (illegal has priority).
  - No PC or regfile write.
  - Transition: -> IDLE.
- link_step2 = ins_c & (IALIGN==16). It is held for the whole operation from DECODE through WB_J.

## Timing
- Reset: state = IDLE, every registered output = 0, taken latch = 0. Constants are unaffected.
- Reset mid-operation aborts immediately; no writeback or done occurs after release.
- Latency: start sampled at edge N. DECODE is N+1, EXEC_* is N+2, RESOLVE is N+3, WB_*/TRAP is N+4. done is high for the cycle after edge N+4.
- Back-to-back: start may be high in the cycle done is high. It is then sampled in the following IDLE cycle, so minimum issue interval is 5 cycles.
- Flags and tgt_lsb are sampled only in RESOLVE.
- ins, code and ins_c must stay stable from start until done.

## Structure
- Shared package fsm_pkg holds:
  - state localparams;
  - funct3 branch codes (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - opdecoder bit indices CODE_BRANCH=24 and CODE_JALR=25.
- Natural sub-module: branch_cond (combinational funct3 + flags -> taken, illegal), reusable by a future fused-compare FSM.

## Test plan
- JAL, tgt_lsb=00, start pulse: done at N+4 with load_regfile=1, sel_pc_next=1, load_pc=1; sel_alu_a=1 in EXEC_J.
- JALR with tgt_lsb=01 (IALIGN=32): clr_lsb=1, sel_alu_a=0, no trap, WB_J reached.
- BLT with ls=1, tgt_lsb=00: WB_B with sel_pc_alu=1. BGEU with lu=1: sel_pc_alu=0. Funct3=010: trap_illegal=1, load_pc stays 0.
- BNE with eq=0, tgt_lsb=10 (IALIGN=32): trap_misaligned=1, no PC load. Same with eq=1 (not taken): WB_B, sel_pc_alu=0, no trap.
- IALIGN=16, ins_c=1, JAL, tgt_lsb=10: no trap, link_step2=1 through WB_J. Same stimulus with IALIGN=32: trap_illegal.
- rst asserted in EXEC_B: all outputs 0 immediately, no done. start held high across done: second operation begins exactly one cycle after done.
